// File: rtl/rca_serial_add_ctrl_pkg.sv
// rca_serial_add_ctrl_pkg: shared state encodings and nibble width for the serial adder controller
package rca_serial_add_ctrl_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/rca_serial_add_ctrl_if.sv
// rca_serial_add_ctrl_if: host-side request/result bundle of the serial adder controller
interface rca_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, in1, in2, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, in1, in2, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/rca_serial_add_ctrl_rca_4bit.sv
// rca_4bit: 4-bit ripple-carry adder built from a chain of full adders
module rca_4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = in1[i] ^ in2[i] ^ c[i];
      c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end
  end
  assign cout = c[4];
endmodule

// File: rtl/rca_serial_add_ctrl.sv
// rca_serial_add_ctrl: WIDTH-bit add done one nibble per clock, LSB first, on a single shared rca_4bit
module rca_serial_add_ctrl
  import rca_serial_add_ctrl_pkg::*;
#(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  rca_serial_add_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [WIDTH-1:0] a, a_d, b, b_d, sum, sum_d;
  logic carry, carry_d, cout, cout_d, ovf, ovf_d, busy, busy_d, done, done_d;
  logic [NIBBLE_W-1:0] rs;
  logic rc;
  rca_4bit u_rca (
    .in1 (a[idx*NIBBLE_W +: NIBBLE_W]),
    .in2 (b[idx*NIBBLE_W +: NIBBLE_W]),
    .cin (carry),
    .sum (rs),
    .cout(rc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a     <= '0;
      b     <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      a     <= a_d;
      b     <= b_d;
      carry <= carry_d;
      sum   <= sum_d;
      cout  <= cout_d;
      ovf   <= ovf_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end
  // DONE accepts start just like IDLE so back-to-back adds have no gap
  always_comb begin
    state_d = state;
    idx_d   = idx;
    a_d     = a;
    b_d     = b;
    carry_d = carry;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = ovf;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if ((state == IDLE || state == DONE) && bus.start) begin
      a_d     = bus.in1;
      b_d     = bus.in2;
      carry_d = bus.cin;
      idx_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else if (state == RUN) begin
      sum_d[idx*NIBBLE_W +: NIBBLE_W] = rs;
      carry_d = rc;
      idx_d   = (idx == LAST) ? '0 : idx + 1'b1;
      busy_d  = (idx != LAST);
      done_d  = (idx == LAST);
      state_d = (idx == LAST) ? DONE : RUN;
      cout_d  = (idx == LAST) ? rc : cout;
      ovf_d   = (idx == LAST) ? (a[WIDTH-1] == b[WIDTH-1]) && (rs[NIBBLE_W-1] != a[WIDTH-1]) : ovf;
    end else begin
      state_d = IDLE;
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum;
  assign bus.cout = cout;
  assign bus.ovf  = ovf;
endmodule

// File: doc/rca_serial_add_ctrl.md
Name: rca_serial_add_ctrl

Overview:
- Multi-cycle controller that performs a WIDTH-bit addition by reusing a single instance of the existing 4-bit ripple-carry adder, one nibble per clock, LSB first.
- Latches the operands on a start handshake, steps a nibble index, and registers the carry between nibbles.
- Assembles the WIDTH-bit sum and reports completion with a one-cycle done pulse.
- Sits between a host/sequencer and the shared 4-bit adder datapath.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps (derived; not overridden).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request to begin an addition; sampled on the rising clk edge.
- in1  input  WIDTH  operand A; captured when start is accepted.
- in2  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in to nibble 0; captured when start is accepted.
- busy  output  1  high while nibbles are being processed (RUN).
- done  output  1  one-cycle pulse when sum/cout/ovf are valid.
- sum  output  WIDTH  registered result; holds until the next accepted start.
- cout  output  1  carry out of the MSB nibble.
- ovf  output  1  two's-complement signed overflow of the full-width add.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, busy=0, done=0, sum=0, cout=0, ovf=0, operand/carry registers=0. Reset mid-operation aborts the add; no done pulse follows.
- States are IDLE, RUN and DONE.
- IDLE: if start=1 at edge k:
  - latch in1, in2, cin;
  - idx<=0, busy<=1, state<=RUN;
  - sum<=0, cout<=0, ovf<=0.
- RUN, one nibble per edge, at edges k+1 .. k+NIB:
  - the adder is fed A[4*idx+:4], B[4*idx+:4] and the carry register;
  - sum[4*idx+:4] <= adder sum; carry <= adder cout; idx <= idx+1.
- RUN exit, at the edge where idx=NIB-1:
  - cout <= adder cout;
  - ovf <= (A[W-1]==B[W-1]) && (final sum[W-1] != A[W-1]);
  - busy<=0, done<=1, state<=DONE.
- Latency: done is high during the cycle after edge k+NIB, i.e. NIB+1 edges after start is sampled (5 for WIDTH=16).
- DONE: lasts exactly one cycle; done<=0 on exit.
  - If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back; busy re-asserts with no gap).
  - Otherwise state<=IDLE.
- start while in RUN is ignored: operands are not relatched and the in-flight result is unaffected.
- in1/in2/cin may change freely after acceptance; only the latched copies are used.
- sum, cout and ovf are registered, glitch-free outputs. The partial sum is visible during RUN and is valid only when done=1 or afterwards in IDLE.
- Arithmetic is modulo 2^WIDTH: the carry out of nibble NIB-1 goes only to cout and never wraps into nibble 0.
- idx width is clog2(NIB). It never exceeds NIB-1 and never wraps during RUN.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE;
  - NIBBLE_W=4 constant.
- Sub-module: the existing rca_4bit, instantiated once (in1, in2, cin, sum, cout) as the shared datapath.
- The controller holds only the FSM, index counter, operand/carry registers and result assembly.

Test Plan:
- WIDTH=16, in1=0x1234, in2=0x4321, cin=0, start at edge k -> busy high for 4 cycles; done one cycle after edge k+4; sum=0x5555, cout=0, ovf=0.
- in1=0xFFFF, in2=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibble steps); repeat with in2=0x0000, cin=1 -> same result.
- in1=0x7FFF, in2=0x0001 -> sum=0x8000, cout=0, ovf=1. Then in1=0x8000, in2=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Start 0x00F0+0x0010; during RUN pulse start with in1=0xAAAA and change in1/in2 -> the pulse is ignored; result is 0x0100, cout=0; exactly one done pulse.
- Back-to-back: start held high through DONE with new operands 0x0003+0x0004 -> second add begins with no idle cycle; second done gives 0x0007.
- Drop rst_n low for 1 cycle after 2 RUN steps -> busy=0, sum=0, no done. A new start after reset gives a correct full result.
